// File: rtl/reg_write_buffer.sv
// reg_write_buffer
//   Write-side initiator for the 8x8 register file. Writeback results are
//   accepted over a valid/ready handshake, queued in a small FIFO and drained
//   one entry per cycle into the register file write port. A combinational
//   lookup port lets the read side forward values that are still pending.
//
// Optional feature macro: REG_WRITE_BUFFER_BYPASS_EN
//   When defined, the lookup also sees the request being accepted this cycle
//   at highest priority. This adds a combinational path from REQ_* to LK_*.
//
// Ports:
//   CLK        clock, rising edge
//   RESET      asynchronous active-low reset
//   REQ_VALID  request valid            REQ_READY  buffer can accept
//   REQ_ADDR   destination register     REQ_DATA   value to write
//   WB_HOLD    register file busy, suppresses draining
//   WRITE      registered write enable to the register file
//   INADDRESS  registered write address
//   WRDATA     registered write data
//   LK_ADDR    lookup address           LK_HIT     pending write exists
//   LK_DATA    newest pending value (0 on miss)
//   COUNT      number of occupied FIFO entries
module reg_write_buffer #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    REQ_VALID,
  output logic                    REQ_READY,
  input  logic [ADDR_WIDTH-1:0]   REQ_ADDR,
  input  logic [DATA_WIDTH-1:0]   REQ_DATA,
  input  logic                    WB_HOLD,
  output logic                    WRITE,
  output logic [ADDR_WIDTH-1:0]   INADDRESS,
  output logic [DATA_WIDTH-1:0]   WRDATA,
  input  logic [ADDR_WIDTH-1:0]   LK_ADDR,
  output logic                    LK_HIT,
  output logic [DATA_WIDTH-1:0]   LK_DATA,
  output logic [$clog2(DEPTH):0]  COUNT
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  logic [DEPTH-1:0]      valid_reg, valid_next;
  logic [PTR_W-1:0]      head_reg, tail_reg;
  logic [CNT_W-1:0]      count_reg, count_next;
  logic                  write_reg;
  logic [ADDR_WIDTH-1:0] inaddress_reg;
  logic [DATA_WIDTH-1:0] wrdata_reg;

  logic push;
  logic pop;

  // Readiness is based on occupancy alone so a full buffer never accepts,
  // even when an entry drains in the same cycle.
  assign REQ_READY = RESET && (count_reg < FULL_COUNT);
  assign push      = REQ_VALID && REQ_READY;
  assign pop       = !WB_HOLD && (count_reg != '0);

  // Push and pop can never target the same slot: a push needs a free slot and
  // a pop needs an occupied head, so the two updates below never collide.
  always_comb begin
    valid_next = valid_reg;
    if (pop)  valid_next[head_reg] = 1'b0;
    if (push) valid_next[tail_reg] = 1'b1;
  end

  assign count_next = count_reg + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      valid_reg     <= '0;
      write_reg     <= 1'b0;
      inaddress_reg <= '0;
      wrdata_reg    <= '0;
    end else begin
      valid_reg <= valid_next;
      count_reg <= count_next;
      if (push) tail_reg <= tail_reg + PTR_W'(1);
      if (pop) begin
        head_reg      <= head_reg + PTR_W'(1);
        write_reg     <= 1'b1;
        inaddress_reg <= addr_mem[head_reg];
        wrdata_reg    <= data_mem[head_reg];
      end else begin
        write_reg <= 1'b0;
      end
    end
  end

  // Entry storage carries no reset; occupancy is tracked by valid_reg.
  always_ff @(posedge CLK) begin
    if (push) begin
      addr_mem[tail_reg] <= REQ_ADDR;
      data_mem[tail_reg] <= REQ_DATA;
    end
  end

  // Per-age match vector: age 0 is the head (oldest), age DEPTH-1 the
  // youngest possible slot.
  logic [DEPTH-1:0]      age_match;
  logic [DATA_WIDTH-1:0] age_data [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_age
      logic [PTR_W-1:0] slot;
      assign slot          = head_reg + PTR_W'(gi);
      assign age_match[gi] = valid_reg[slot] && (addr_mem[slot] == LK_ADDR);
      assign age_data[gi]  = data_mem[slot];
    end
  endgenerate

  // Later assignments override earlier ones, so the search runs from oldest
  // (output stage) to youngest and the last match wins.
  logic                  lk_hit;
  logic [DATA_WIDTH-1:0] lk_data;

  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    if (write_reg && (inaddress_reg == LK_ADDR)) begin
      lk_hit  = 1'b1;
      lk_data = wrdata_reg;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (age_match[i]) begin
        lk_hit  = 1'b1;
        lk_data = age_data[i];
      end
    end
`ifdef REG_WRITE_BUFFER_BYPASS_EN
    if (push && (REQ_ADDR == LK_ADDR)) begin
      lk_hit  = 1'b1;
      lk_data = REQ_DATA;
    end
`endif
  end

  assign LK_HIT    = lk_hit;
  assign LK_DATA   = lk_data;
  assign WRITE     = write_reg;
  assign INADDRESS = inaddress_reg;
  assign WRDATA    = wrdata_reg;
  assign COUNT     = count_reg;

endmodule

// File: tb/tb_reg_write_buffer.sv
// tb_reg_write_buffer
//   Self-checking bench for reg_write_buffer. Directed scenarios followed by
//   random traffic, all compared against a queue-based reference model.
//   Honours REG_WRITE_BUFFER_BYPASS_EN when the same define is applied.
module tb_reg_write_buffer;

  localparam int DEPTH = 4;
  localparam int DW    = 8;
  localparam int AW    = 3;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          REQ_VALID = 1'b0;
  logic          REQ_READY;
  logic [AW-1:0] REQ_ADDR = '0;
  logic [DW-1:0] REQ_DATA = '0;
  logic          WB_HOLD = 1'b0;
  logic          WRITE;
  logic [AW-1:0] INADDRESS;
  logic [DW-1:0] WRDATA;
  logic [AW-1:0] LK_ADDR = '0;
  logic          LK_HIT;
  logic [DW-1:0] LK_DATA;
  logic [$clog2(DEPTH):0] COUNT;

  always #5 CLK = ~CLK;

  reg_write_buffer #(
    .DEPTH(DEPTH),
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .REQ_VALID(REQ_VALID),
    .REQ_READY(REQ_READY),
    .REQ_ADDR(REQ_ADDR),
    .REQ_DATA(REQ_DATA),
    .WB_HOLD(WB_HOLD),
    .WRITE(WRITE),
    .INADDRESS(INADDRESS),
    .WRDATA(WRDATA),
    .LK_ADDR(LK_ADDR),
    .LK_HIT(LK_HIT),
    .LK_DATA(LK_DATA),
    .COUNT(COUNT)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a plain queue of pending (addr, data) pairs plus the
  // register-file write stage.
  int q_addr[$];
  int q_data[$];
  bit m_write;
  int m_addr;
  int m_data;

  task automatic model_reset();
    q_addr.delete();
    q_data.delete();
    m_write = 1'b0;
    m_addr  = 0;
    m_data  = 0;
  endtask

  task automatic compare_model(input string tag);
    bit ready;
    bit exp_hit;
    int exp_data;
    ready    = (q_addr.size() < DEPTH);
    exp_hit  = 1'b0;
    exp_data = 0;
    check_val({tag, "_ready"}, {31'd0, REQ_READY}, {31'd0, ready});
    check_val({tag, "_count"}, 32'(COUNT), q_addr.size());
    check_val({tag, "_write"}, {31'd0, WRITE}, {31'd0, m_write});
    check_val({tag, "_inaddr"}, 32'(INADDRESS), m_addr);
    check_val({tag, "_wrdata"}, 32'(WRDATA), m_data);
    if (m_write && (m_addr == int'(LK_ADDR))) begin
      exp_hit  = 1'b1;
      exp_data = m_data;
    end
    foreach (q_addr[i]) begin
      if (q_addr[i] == int'(LK_ADDR)) begin
        exp_hit  = 1'b1;
        exp_data = q_data[i];
      end
    end
`ifdef REG_WRITE_BUFFER_BYPASS_EN
    if (REQ_VALID && ready && (REQ_ADDR == LK_ADDR)) begin
      exp_hit  = 1'b1;
      exp_data = int'(REQ_DATA);
    end
`endif
    check_val({tag, "_lkhit"}, {31'd0, LK_HIT}, {31'd0, exp_hit});
    check_val({tag, "_lkdata"}, 32'(LK_DATA), exp_data);
  endtask

  task automatic model_step(input string tag);
    bit do_push;
    bit do_pop;
    do_push = REQ_VALID && (q_addr.size() < DEPTH);
    do_pop  = !WB_HOLD && (q_addr.size() > 0);
    if (do_pop) begin
      m_write = 1'b1;
      m_addr  = q_addr.pop_front();
      m_data  = q_data.pop_front();
      $display("%s: drain addr=%0d data=0x%02h", tag, m_addr, m_data);
    end else begin
      m_write = 1'b0;
    end
    if (do_push) begin
      q_addr.push_back(int'(REQ_ADDR));
      q_data.push_back(int'(REQ_DATA));
    end
  endtask

  // One clock cycle: drive at posedge+1, check and advance the model at the
  // negedge, return at the following posedge+1.
  task automatic step(input bit v, input int a, input int d, input bit h, input int lk,
                      input string tag);
    REQ_VALID = v;
    REQ_ADDR  = AW'(a);
    REQ_DATA  = DW'(d);
    WB_HOLD   = h;
    LK_ADDR   = AW'(lk);
    @(negedge CLK);
    compare_model(tag);
    model_step(tag);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    model_reset();

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_val("rst_ready", {31'd0, REQ_READY}, 0);
    check_val("rst_count", 32'(COUNT), 0);
    check_val("rst_write", {31'd0, WRITE}, 0);
    RESET = 1'b1;
    @(posedge CLK);
    #1;

    // Single push -> write one cycle after the push edge
    step(1'b1, 3, 'hA5, 1'b0, 0, "t1_push");
    step(1'b0, 0, 0, 1'b0, 3, "t1_wait");
    check_val("t1_write", {31'd0, WRITE}, 1);
    check_val("t1_inaddr", 32'(INADDRESS), 3);
    check_val("t1_wrdata", 32'(WRDATA), 'hA5);
    step(1'b0, 0, 0, 1'b0, 3, "t1_idle");
    check_val("t1_write_off", {31'd0, WRITE}, 0);
    check_val("t1_count", 32'(COUNT), 0);

    // Fill under hold, overflow attempt, ordered drain
    for (int k = 1; k <= 4; k++) step(1'b1, k, k * 'h11, 1'b1, 0, "t2_fill");
    check_val("t2_ready_full", {31'd0, REQ_READY}, 0);
    check_val("t2_count_full", 32'(COUNT), 4);
    step(1'b1, 5, 'h55, 1'b1, 0, "t2_over");
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 0, 0, 1'b0, k, "t2_drain");
      check_val("t2_write", {31'd0, WRITE}, 1);
      check_val("t2_inaddr", 32'(INADDRESS), k);
      check_val("t2_wrdata", 32'(WRDATA), k * 'h11);
    end
    step(1'b0, 0, 0, 1'b0, 0, "t2_end");
    check_val("t2_write_off", {31'd0, WRITE}, 0);

    // Full buffer with draining and REQ_VALID held
    for (int k = 0; k < 4; k++) step(1'b1, k + 4, 'h60 + k, 1'b1, 0, "t3_fill");
    for (int k = 0; k < 12; k++)
      step(1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), 1'b0,
           int'($urandom_range(0, 7)), "t3_stream");
    repeat (6) step(1'b0, 0, 0, 1'b0, int'($urandom_range(0, 7)), "t3_drain");

    // Lookup: newest of two writes to the same register
    step(1'b1, 5, 'h10, 1'b1, 0, "t4_push");
    step(1'b1, 5, 'h20, 1'b1, 0, "t4_push");
    REQ_VALID = 1'b0;
    LK_ADDR   = 3'd5;
    #1;
    check_val("t4_hit5", {31'd0, LK_HIT}, 1);
    check_val("t4_data5", 32'(LK_DATA), 'h20);
    LK_ADDR = 3'd6;
    #1;
    check_val("t4_hit6", {31'd0, LK_HIT}, 0);
    check_val("t4_data6", 32'(LK_DATA), 0);
    repeat (4) step(1'b0, 0, 0, 1'b0, 5, "t4_drain");

    // Lookup hitting only the output stage
    step(1'b1, 7, 'h7F, 1'b0, 7, "t5_push");
    step(1'b0, 0, 0, 1'b0, 7, "t5_issue");
    #1;
    check_val("t5_write", {31'd0, WRITE}, 1);
    check_val("t5_count", 32'(COUNT), 0);
    check_val("t5_hit", {31'd0, LK_HIT}, 1);
    check_val("t5_data", 32'(LK_DATA), 'h7F);
    step(1'b0, 0, 0, 1'b0, 7, "t5_after");
    #1;
    check_val("t5_hit_off", {31'd0, LK_HIT}, 0);
    check_val("t5_data_off", 32'(LK_DATA), 0);

    // Asynchronous reset in mid-drain
    for (int k = 1; k <= 3; k++) step(1'b1, k, 'hC0 + k, 1'b1, 0, "t6_fill");
    step(1'b0, 0, 0, 1'b0, 0, "t6_drain");
    check_val("t6_write_pre", {31'd0, WRITE}, 1);
    RESET     = 1'b0;
    REQ_VALID = 1'b1;
    #1;
    check_val("t6_write_rst", {31'd0, WRITE}, 0);
    check_val("t6_count_rst", 32'(COUNT), 0);
    check_val("t6_ready_rst", {31'd0, REQ_READY}, 0);
    model_reset();
    @(posedge CLK);
    #1;
    check_val("t6_count_hold", 32'(COUNT), 0);
    @(negedge CLK);
    RESET     = 1'b1;
    REQ_VALID = 1'b0;
    @(posedge CLK);
    #1;
    for (int k = 0; k < 5; k++) step(1'b0, 0, 0, 1'b0, k + 1, "t6_post");

    // Random traffic against the model
    for (int k = 0; k < 600; k++)
      step($urandom_range(0, 99) < 60, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
           $urandom_range(0, 99) < 30, int'($urandom_range(0, 7)), "rand");
    repeat (6) step(1'b0, 0, 0, 1'b0, 0, "flush");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_write_buffer.md
Name: reg_write_buffer

Overview:
- Write-side initiator for the 8x8 register file.
- Accepts (address, data) writeback results from the execute/memory stages through a valid/ready handshake and queues them in a small FIFO.
- Drains one entry per cycle into the register file's write port (write enable, write address, write data).
- Provides a combinational lookup port so the read side can forward pending, not-yet-committed values.

Parameters:
DEPTH, 4, number of FIFO entries (power of two, >= 2)
DATA_WIDTH, 8, width of register data
ADDR_WIDTH, 3, width of register address (8 registers)

Ports:
CLK  input  1  clock; all state updates on the rising edge
RESET  input  1  asynchronous, active-low reset
REQ_VALID  input  1  writeback request valid
REQ_READY  output  1  buffer can accept a request this cycle
REQ_ADDR  input  ADDR_WIDTH  destination register of the request
REQ_DATA  input  DATA_WIDTH  value to write
WB_HOLD  input  1  register file busy; suppresses draining
WRITE  output  1  write enable to register file (registered)
INADDRESS  output  ADDR_WIDTH  write address to register file (registered)
WRDATA  output  DATA_WIDTH  write data to register file (registered)
LK_ADDR  input  ADDR_WIDTH  lookup address from the read side
LK_HIT  output  1  a pending write to LK_ADDR exists
LK_DATA  output  DATA_WIDTH  newest pending value for LK_ADDR; 0 when no hit
COUNT  output  clog2(DEPTH)+1  number of occupied FIFO entries

Behaviour:
- Reset (RESET low, asynchronous):
  - Pointers and COUNT cleared to 0.
  - WRITE, INADDRESS and WRDATA cleared to 0.
  - All FIFO entries invalidated.
  - REQ_READY forced to 0 while RESET is low.
  - A reset in mid-drain discards every queued entry and cancels any in-flight WRITE pulse.
- Accept:
  - REQ_READY = (COUNT < DEPTH). It does not depend on a pop in the same cycle.
  - A push happens on a rising edge when REQ_VALID && REQ_READY: the entry is written at the tail and the tail wraps modulo DEPTH.
- Drain:
  - On each rising edge, if !WB_HOLD && COUNT > 0: pop the head entry into the output stage and set WRITE=1, INADDRESS=head.addr, WRDATA=head.data.
  - Otherwise WRITE=0. INADDRESS and WRDATA hold their previous values.
  - WRITE is a one-cycle pulse per entry. Back-to-back entries give continuous WRITE=1 with a new address each cycle.
- Latency:
  - A request pushed into an empty buffer at edge N appears on WRITE/INADDRESS/WRDATA after edge N+1.
  - The register file commits it at edge N+2.
- Simultaneous push and pop: both take effect. COUNT is unchanged and order is preserved.
- Full: a request is not accepted even if a pop happens in the same cycle.
- Empty: a push in the current cycle is not poppable until the next edge; there is no same-cycle bypass to WRITE.
- Ordering: strict FIFO. Writes to the same address commit in acceptance order.
- Lookup (combinational):
  - Search set is all valid FIFO entries plus the output stage while WRITE=1.
  - The youngest match wins: FIFO entries are younger than the output stage, and within the FIFO the entry nearest the tail wins.
  - LK_HIT=0 and LK_DATA=0 when nothing matches.
- No special treatment of register 0; it is writable like any other.

Optional Feature:
- Macro: REG_WRITE_BUFFER_BYPASS_EN.
- Defined:
  - The lookup search set also includes the request being accepted this cycle (REQ_VALID && REQ_READY && REQ_ADDR==LK_ADDR), at highest priority, with LK_DATA=REQ_DATA.
  - This adds a combinational path from REQ_* to LK_*.
- Not defined: lookup covers only stored entries and the output stage, as described in Behaviour.

Test Plan:
- Reset then single push (addr 3, data 0xA5) with WB_HOLD=0 -> WRITE=1, INADDRESS=3, WRDATA=0xA5 one cycle after the push edge, WRITE=0 the following cycle, COUNT back to 0.
- WB_HOLD=1, push 4 entries (1:0x11, 2:0x22, 3:0x33, 4:0x44), then attempt a 5th -> REQ_READY=0 and COUNT=4. Release hold -> four consecutive WRITE cycles in order 1,2,3,4.
- Full buffer with WB_HOLD=0 and REQ_VALID held -> each cycle one pop occurs; a push is accepted only on cycles that start with COUNT<4. No entry is lost or duplicated.
- Push 5:0x10 then 5:0x20 under hold, LK_ADDR=5 -> LK_HIT=1, LK_DATA=0x20. LK_ADDR=6 -> LK_HIT=0, LK_DATA=0.
- Drain to the last entry (output stage only, 7:0x7F) -> LK_ADDR=7 gives LK_HIT=1, LK_DATA=0x7F while WRITE=1, and LK_HIT=0 the next cycle.
- Assert RESET low mid-drain with 3 queued -> WRITE=0, COUNT=0 immediately, REQ_READY=0 during reset. After release, no stale writes appear.
